// File: rtl/sopc_keyctrl_pkg.sv
// sopc_keyctrl_pkg: shared constants for the SOPC key interrupt controller
//   register map, CTRL bit layout and reset value, maximum key count
package sopc_keyctrl_pkg;
    typedef enum logic [1:0] {
        ADDR_STATUS  = 2'd0,
        ADDR_MASK    = 2'd1,
        ADDR_PENDING = 2'd2,
        ADDR_CTRL    = 2'd3
    } reg_addr_e;
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_REPEAT = 1;
    localparam logic [1:0] CTRL_RESET = 2'b01;
    localparam int MAX_KEYS = 8;
endpackage

// File: rtl/sopc_key_debounce.sv
// sopc_key_debounce: one key's synchroniser, tick-sampled debouncer and press pulse
//   clk, rst_n : clock, asynchronous active-low reset
//   key_n      : raw button, 0 = pressed
//   tick       : sample strobe
//   stable     : debounced level, 1 = pressed
//   press      : one-clock pulse on a stable 0->1 change
module sopc_key_debounce
    import sopc_keyctrl_pkg::*;
#(
    parameter int STABLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    input  logic tick,
    output logic stable,
    output logic press
);
    logic [1:0] sync;
    logic [3:0] cnt;
    logic       sample;
    logic       hit;
    assign sample = ~sync[1];
    // this tick's disagreeing sample completes the run of STABLE
    assign hit = tick && (sample != stable) && (cnt + 4'd1 == 4'(STABLE));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= 2'b11;
            cnt    <= '0;
            stable <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= hit && sample;
            if (tick) begin
                cnt <= (sample == stable || hit) ? 4'd0 : cnt + 4'd1;
                if (hit) stable <= sample;
            end
        end
    end
endmodule

// File: rtl/sopc_key_irq_ctrl.sv
// sopc_key_irq_ctrl: debounced multi-key press latch with masked, enabled level IRQ
//   csi_clockreset_clk/_reset_n : clock, asynchronous active-low reset
//   avs_ctrl_*                  : Avalon slave, regs STATUS/MASK/PENDING(W1C)/CTRL
//   ins_intrq_irq               : registered level interrupt
//   KEY                         : raw active-low buttons
//   SOPC_KEYCTRL_REPEAT_EN      : adds auto-repeat events (CTRL bit1)
module sopc_key_irq_ctrl
    import sopc_keyctrl_pkg::*;
#(
    parameter int NKEYS  = 4,
    parameter int DIV_W  = 16,
    parameter int STABLE = 2
`ifdef SOPC_KEYCTRL_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
`endif
) (
    input  logic             csi_clockreset_clk,
    input  logic             csi_clockreset_reset_n,
    input  logic [1:0]       avs_ctrl_address,
    input  logic             avs_ctrl_read,
    input  logic             avs_ctrl_write,
    input  logic [7:0]       avs_ctrl_writedata,
    output logic [7:0]       avs_ctrl_readdata,
    output logic             avs_ctrl_waitrequest_n,
    output logic             ins_intrq_irq,
    input  logic [NKEYS-1:0] KEY
);
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;
    logic [NKEYS-1:0] status, press, event_v, pending, mask, wdata;
    logic             ctrl_en, ctrl_rep;
    logic             unused_ok;
    assign tick                   = &tick_cnt;
    assign wdata                  = avs_ctrl_writedata[NKEYS-1:0];
    assign avs_ctrl_waitrequest_n = 1'b1;
    assign unused_ok              = ^{avs_ctrl_read, avs_ctrl_writedata};
    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        sopc_key_debounce #(.STABLE(STABLE)) u_db (
            .clk    (csi_clockreset_clk),
            .rst_n  (csi_clockreset_reset_n),
            .key_n  (KEY[k]),
            .tick   (tick),
            .stable (status[k]),
            .press  (press[k])
        );
`ifdef SOPC_KEYCTRL_REPEAT_EN
        // rdone selects the inter-repeat period once the initial delay has elapsed
        logic [7:0] rcnt;
        logic [7:0] rlim;
        logic       rdone, rep;
        assign rlim = rdone ? 8'(REPEAT_RATE) : 8'(REPEAT_DELAY);
        always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
            if (!csi_clockreset_reset_n) begin
                rcnt  <= '0;
                rdone <= 1'b0;
                rep   <= 1'b0;
            end else if (!status[k] || !ctrl_rep) begin
                rcnt  <= '0;
                rdone <= 1'b0;
                rep   <= 1'b0;
            end else begin
                rep <= tick && (rcnt + 8'd1 == rlim);
                if (tick) begin
                    rcnt  <= (rcnt + 8'd1 == rlim) ? 8'd0 : rcnt + 8'd1;
                    rdone <= rdone || (rcnt + 8'd1 == rlim);
                end
            end
        end
        assign event_v[k] = press[k] | rep;
`else
        assign event_v[k] = press[k];
`endif
    end
`ifdef SOPC_KEYCTRL_REPEAT_EN
    always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
        if (!csi_clockreset_reset_n) ctrl_rep <= CTRL_RESET[CTRL_REPEAT];
        else if (avs_ctrl_write && avs_ctrl_address == ADDR_CTRL) ctrl_rep <= avs_ctrl_writedata[CTRL_REPEAT];
    end
`else
    assign ctrl_rep = 1'b0;
`endif
    always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
        if (!csi_clockreset_reset_n) begin
            tick_cnt      <= '0;
            mask          <= '0;
            pending       <= '0;
            ctrl_en       <= CTRL_RESET[CTRL_ENABLE];
            ins_intrq_irq <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
            if (avs_ctrl_write && avs_ctrl_address == ADDR_MASK) mask <= wdata;
            if (avs_ctrl_write && avs_ctrl_address == ADDR_CTRL) ctrl_en <= avs_ctrl_writedata[CTRL_ENABLE];
            // new events are ORed in after the clear so a same-cycle set survives
            pending <= (pending & ~((avs_ctrl_write && avs_ctrl_address == ADDR_PENDING) ? wdata : '0)) | event_v;
            ins_intrq_irq <= ctrl_en & |(pending & mask);
        end
    end
    always_comb begin
        avs_ctrl_readdata = avs_ctrl_address == ADDR_STATUS  ? 8'(status)  :
                            avs_ctrl_address == ADDR_MASK    ? 8'(mask)    :
                            avs_ctrl_address == ADDR_PENDING ? 8'(pending) :
                                                               {6'b0, ctrl_rep, ctrl_en};
    end
endmodule

// File: tb/tb_sopc_key_irq_ctrl.sv
// tb_sopc_key_irq_ctrl: scenario bench for the key interrupt controller
module tb_sopc_key_irq_ctrl;
    import sopc_keyctrl_pkg::*;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] addr = 2'd0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wd = 8'h00;
    logic [7:0] rdata;
    logic       wrn, irq;
    logic [3:0] key = 4'hF;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] d, e;
    logic       ok;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    sopc_key_irq_ctrl #(
        .NKEYS(4), .DIV_W(4), .STABLE(2)
`ifdef SOPC_KEYCTRL_REPEAT_EN
        , .REPEAT_DELAY(4), .REPEAT_RATE(2)
`endif
    ) dut (
        .csi_clockreset_clk     (clk),
        .csi_clockreset_reset_n (rst_n),
        .avs_ctrl_address       (addr),
        .avs_ctrl_read          (rd),
        .avs_ctrl_write         (wr),
        .avs_ctrl_writedata     (wd),
        .avs_ctrl_readdata      (rdata),
        .avs_ctrl_waitrequest_n (wrn),
        .ins_intrq_irq          (irq),
        .KEY                    (key)
    );

    task automatic wreg(input logic [1:0] a, input logic [7:0] v);
        @(negedge clk);
        addr = a; wd = v; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rreg(input logic [1:0] a, output logic [7:0] v);
        addr = a; rd = 1'b1;
        #1;
        v = rdata; rd = 1'b0;
    endtask

    task automatic wait_bit(input logic [1:0] a, input logic [7:0] m, input int lim, output logic found);
        logic [7:0] v;
        found = 1'b0;
        for (int i = 0; i < lim && !found; i++) begin
            @(negedge clk);
            rreg(a, v);
            found = (v & m) != 8'h00;
        end
    endtask

    task automatic test_reset;
        logic [7:0] rv [4] = '{8'h00, 8'h00, 8'h00, 8'h01};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(rv[i]);
            rreg(2'(i), d); e = exp_q.pop_front(); tests++;
            if (d !== e) begin fails++; $display("FAIL reset_reg%0d got %h exp %h", i, d, e); end
        end
        exp_q.push_back(8'h00);
        e = exp_q.pop_front(); tests++;
        if (8'(irq) !== e) begin fails++; $display("FAIL reset_irq got %h exp %h", irq, e); end
        exp_q.push_back(8'h01);
        e = exp_q.pop_front(); tests++;
        if (8'(wrn) !== e) begin fails++; $display("FAIL waitreq_n got %h exp %h", wrn, e); end
    endtask

    task automatic test_press;
        wreg(ADDR_MASK, 8'h01);
        key[0] = 1'b0;
        exp_q.push_back(8'h01);
        wait_bit(ADDR_PENDING, 8'h01, 200, ok); e = exp_q.pop_front(); tests++;
        if (8'(ok) !== e) begin fails++; $display("FAIL press_pending_set got %h exp %h", ok, e); end
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        e = exp_q.pop_front(); tests++;
        if (8'(irq) !== e) begin fails++; $display("FAIL press_irq_early got %h exp %h", irq, e); end
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (8'(irq) !== e) begin fails++; $display("FAIL press_irq got %h exp %h", irq, e); end
        repeat (40) @(negedge clk);
        exp_q.push_back(8'h01); exp_q.push_back(8'h01);
        rreg(ADDR_STATUS, d); e = exp_q.pop_front(); tests++;
        if (d !== e) begin fails++; $display("FAIL press_status got %h exp %h", d, e); end
        rreg(ADDR_PENDING, d); e = exp_q.pop_front(); tests++;
        if (d !== e) begin fails++; $display("FAIL press_pending got %h exp %h", d, e); end
        wreg(ADDR_PENDING, 8'h01);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        rreg(ADDR_PENDING, d); e = exp_q.pop_front(); tests++;
        if (d !== e) begin fails++; $display("FAIL w1c_pending got %h exp %h", d, e); end
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (8'(irq) !== e) begin fails++; $display("FAIL w1c_irq got %h exp %h", irq, e); end
        key[0] = 1'b1;
        repeat (70) @(negedge clk);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        rreg(ADDR_STATUS, d); e = exp_q.pop_front(); tests++;
        if (d !== e) begin fails++; $display("FAIL release_status got %h exp %h", d, e); end
        rreg(ADDR_PENDING, d); e = exp_q.pop_front(); tests++;
        if (d !== e) begin fails++; $display("FAIL release_pending got %h exp %h", d, e); end
    endtask

    task automatic test_glitch;
        key[1] = 1'b0;
        repeat (10) @(negedge clk);
        key[1] = 1'b1;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        repeat (70) @(negedge clk);
        rreg(ADDR_STATUS, d); e = exp_q.pop_front(); tests++;
        if (d !== e) begin fails++; $display("FAIL glitch_status got %h exp %h", d, e); end
        rreg(ADDR_PENDING, d); e = exp_q.pop_front(); tests++;
        if (d !== e) begin fails++; $display("FAIL glitch_pending got %h exp %h", d, e); end
    endtask

    task automatic test_mask;
        wreg(ADDR_MASK, 8'h00);
        key[2] = 1'b0;
        exp_q.push_back(8'h01);
        wait_bit(ADDR_PENDING, 8'h04, 200, ok); e = exp_q.pop_front(); tests++;
        if (8'(ok) !== e) begin fails++; $display("FAIL mask_pending_set got %h exp %h", ok, e); end
        exp_q.push_back(8'h04); exp_q.push_back(8'h00);
        rreg(ADDR_PENDING, d); e = exp_q.pop_front(); tests++;
        if (d !== e) begin fails++; $display("FAIL mask_pending got %h exp %h", d, e); end
        repeat (3) @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (8'(irq) !== e) begin fails++; $display("FAIL masked_irq got %h exp %h", irq, e); end
        wreg(ADDR_MASK, 8'h04);
        exp_q.push_back(8'h01);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (8'(irq) !== e) begin fails++; $display("FAIL unmasked_irq got %h exp %h", irq, e); end
        wreg(ADDR_CTRL, 8'h00);
        exp_q.push_back(8'h00);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (8'(irq) !== e) begin fails++; $display("FAIL disabled_irq got %h exp %h", irq, e); end
        wreg(ADDR_CTRL, 8'h01);
        wreg(ADDR_PENDING, 8'h04);
        key[2] = 1'b1;
        repeat (70) @(negedge clk);
    endtask

    task automatic test_same_cycle;
        logic found;
        found = 1'b0;
        key[3] = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            rreg(ADDR_STATUS, d);
            found = d[3];
        end
        addr = ADDR_PENDING; wd = 8'h08; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        exp_q.push_back(8'h01); exp_q.push_back(8'h08);
        e = exp_q.pop_front(); tests++;
        if (8'(found) !== e) begin fails++; $display("FAIL same_cycle_status got %h exp %h", found, e); end
        rreg(ADDR_PENDING, d); e = exp_q.pop_front(); tests++;
        if (d !== e) begin fails++; $display("FAIL set_wins got %h exp %h", d, e); end
    endtask

    task automatic test_reset_mid;
        wreg(ADDR_MASK, 8'h08);
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        e = exp_q.pop_front(); tests++;
        if (8'(irq) !== e) begin fails++; $display("FAIL pre_reset_irq got %h exp %h", irq, e); end
        #2 rst_n = 1'b0;
        #1;
        e = exp_q.pop_front(); tests++;
        if (8'(irq) !== e) begin fails++; $display("FAIL async_irq got %h exp %h", irq, e); end
        rreg(ADDR_PENDING, d); e = exp_q.pop_front(); tests++;
        if (d !== e) begin fails++; $display("FAIL reset_pending got %h exp %h", d, e); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(8'h01); exp_q.push_back(8'h00);
        wait_bit(ADDR_PENDING, 8'h08, 200, ok); e = exp_q.pop_front(); tests++;
        if (8'(ok) !== e) begin fails++; $display("FAIL held_key_event got %h exp %h", ok, e); end
        rreg(ADDR_MASK, d); e = exp_q.pop_front(); tests++;
        if (d !== e) begin fails++; $display("FAIL reset_mask got %h exp %h", d, e); end
        key[3] = 1'b1;
        repeat (70) @(negedge clk);
        wreg(ADDR_PENDING, 8'hFF);
    endtask

    task automatic test_ctrl;
        wreg(ADDR_CTRL, 8'hFF);
`ifdef SOPC_KEYCTRL_REPEAT_EN
        exp_q.push_back(8'h03);
`else
        exp_q.push_back(8'h01);
`endif
        rreg(ADDR_CTRL, d); e = exp_q.pop_front(); tests++;
        if (d !== e) begin fails++; $display("FAIL ctrl_readback got %h exp %h", d, e); end
        wreg(ADDR_CTRL, 8'h01);
    endtask

`ifdef SOPC_KEYCTRL_REPEAT_EN
    task automatic test_repeat;
        int last;
        wreg(ADDR_CTRL, 8'h03);
        wreg(ADDR_PENDING, 8'hFF);
        key[0] = 1'b0;
        exp_q.push_back(8'h01);
        wait_bit(ADDR_PENDING, 8'h01, 200, ok); e = exp_q.pop_front(); tests++;
        if (8'(ok) !== e) begin fails++; $display("FAIL repeat_press got %h exp %h", ok, e); end
        last = cyc;
        wreg(ADDR_PENDING, 8'h01);
        exp_q.push_back(8'd64); exp_q.push_back(8'd32); exp_q.push_back(8'd32);
        for (int i = 0; i < 3; i++) begin
            wait_bit(ADDR_PENDING, 8'h01, 200, ok);
            d = ok ? 8'(cyc - last) : 8'hFF;
            last = cyc;
            wreg(ADDR_PENDING, 8'h01);
            e = exp_q.pop_front(); tests++;
            if (d !== e) begin fails++; $display("FAIL repeat_gap%0d got %0d exp %0d", i, d, e); end
        end
        key[0] = 1'b1;
        repeat (80) @(negedge clk);
        wreg(ADDR_PENDING, 8'hFF);
        repeat (80) @(negedge clk);
        exp_q.push_back(8'h00);
        rreg(ADDR_PENDING, d); e = exp_q.pop_front(); tests++;
        if (d !== e) begin fails++; $display("FAIL repeat_after_release got %h exp %h", d, e); end
    endtask
`endif

    initial begin
        test_reset;
        test_press;
        test_glitch;
        test_mask;
        test_same_cycle;
        test_reset_mid;
        test_ctrl;
`ifdef SOPC_KEYCTRL_REPEAT_EN
        test_repeat;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
